// File: rtl/multiplier.sv
// Packed fixed-point multiplier: {mantissa, scale} x {mantissa, scale} -> {mantissa, scale}.
// Exact product, then scale clamp, minimal range normalisation and saturation; one registered stage.
module multiplier #(
  parameter int DATA_W  = 16,
  parameter int SCALE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] first_operand,
  input  logic [DATA_W-1:0] second_operand,
  output logic [DATA_W-1:0] out
);

  localparam int MANT_W   = DATA_W - SCALE_W;
  localparam int PROD_W   = 2 * MANT_W;
  localparam int MAX_S    = (1 << SCALE_W) - 1;
  localparam int MANT_MAX = (1 << (MANT_W - 1)) - 1;
  localparam int MANT_MIN = -(1 << (MANT_W - 1));

  localparam logic signed [PROD_W-1:0] P_MAX = PROD_W'(MANT_MAX);
  localparam logic signed [PROD_W-1:0] P_MIN = PROD_W'(MANT_MIN);

  localparam logic [SCALE_W:0] SP_MAX = (SCALE_W + 1)'(MAX_S);

  logic signed [MANT_W-1:0]  ma, mb;
  logic        [SCALE_W-1:0] sa, sb;
  logic signed [PROD_W-1:0]  p_full, p1, p2, trial;
  logic        [SCALE_W:0]   sp;
  logic        [SCALE_W-1:0] sp1, sp2;
  logic                      found;
  logic signed [MANT_W-1:0]  mant;
  logic        [SCALE_W-1:0] scale;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    ma     = $signed(first_operand[DATA_W-1:SCALE_W]);
    mb     = $signed(second_operand[DATA_W-1:SCALE_W]);
    sa     = first_operand[SCALE_W-1:0];
    sb     = second_operand[SCALE_W-1:0];
    p_full = PROD_W'(ma) * PROD_W'(mb);
    sp     = {1'b0, sa} + {1'b0, sb};
    p1     = p_full;
    sp1    = sp[SCALE_W-1:0];
    p2     = '0;
    sp2    = '0;
    trial  = '0;
    found  = 1'b0;
    mant   = '0;
    scale  = '0;

    // Scale beyond the field: fold the excess into an arithmetic (floor) shift.
    if (sp > SP_MAX) begin
      p1  = p_full >>> (sp - SP_MAX);
      sp1 = SCALE_W'(MAX_S);
    end

    // Smallest shift that brings the product into mantissa range without going below scale 0.
    for (int k = 0; k <= MAX_S; k++) begin
      if (!found && k <= int'(sp1)) begin
        trial = p1 >>> k;
        if (trial >= P_MIN && trial <= P_MAX) begin
          found = 1'b1;
          p2    = trial;
          sp2   = sp1 - SCALE_W'(k);
        end
      end
    end

    if (found) begin
      mant  = MANT_W'(p2);
      scale = sp2;
    end else begin
      mant  = p1[PROD_W-1] ? {1'b1, {(MANT_W-1){1'b0}}} : {1'b0, {(MANT_W-1){1'b1}}};
      scale = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment for registered state avoids simulation ordering races.
    if (rst) out <= '0;
    else     out <= {mant, scale};
  end

endmodule

// File: tb/tb_multiplier.sv
// Directed self-checking bench for the packed fixed-point multiplier.
// Operands are driven at the falling edge; the output is checked 1 ns after the next rising edge.
module tb_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] first_operand;
  logic [15:0] second_operand;
  logic [15:0] dut_out;

  int tests = 0;
  int fails = 0;

  multiplier dut (
    .clk            (clk),
    .rst            (rst),
    .first_operand  (first_operand),
    .second_operand (second_operand),
    .out            (dut_out)
  );

  always #5 clk = ~clk;

  // Apply operands/reset, clock once, then compare the registered result.
  task automatic step(input string tag, input logic r, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] expected);
    @(negedge clk);
    rst            = r;
    first_operand  = a;
    second_operand = b;
    @(posedge clk);
    #1;
    tests++;
    assert (dut_out === expected) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, dut_out, expected);
    end
  endtask

  initial begin
    rst            = 1'b1;
    first_operand  = 16'h0000;
    second_operand = 16'h0000;

    step("reset_state",      1'b1, 16'h7FF8, 16'h7FF8, 16'h0000);
    step("exact_pos",        1'b0, 16'h0039, 16'h02A4, 16'h1265);
    step("neg_by_pos",       1'b0, 16'hFF99, 16'h0020, 16'hFE61);
    step("pos_by_neg",       1'b0, 16'h00DA, 16'hFFE0, 16'hFCA2);
    step("scale_overflow",   1'b0, 16'h051D, 16'h058D, 16'h70B7);
    step("range_norm",       1'b0, 16'h7FFA, 16'h0010, 16'h7FF9);
    step("sat_pos",          1'b0, 16'h7FF8, 16'h7FF8, 16'h7FF8);
    step("sat_neg",          1'b0, 16'h8000, 16'h0010, 16'h8000);
    // P = 0, Sp = 14 -> mantissa 0, scale clamped to 7
    step("zero_clamp",       1'b0, 16'h0007, 16'h000F, 16'h0007);
    // P = -1, Sp = 8 -> floor(-1/2) = -1, scale 7
    step("floor_minus1",     1'b0, 16'hFFFF, 16'h0009, 16'hFFFF);
    // P = -3, Sp = 8 -> floor(-3/2) = -2, scale 7
    step("floor_minus3",     1'b0, 16'hFFEF, 16'h0009, 16'hFFF7);
    // P = 4095 / -4096 at scale 0: in range, no saturation
    step("edge_max",         1'b0, 16'h7FF8, 16'h0008, 16'h7FF8);
    step("edge_min",         1'b0, 16'h8000, 16'h0008, 16'h8000);
    // P = 4096, Sp = 1 -> one shift: 2048, scale 0
    step("just_over",        1'b0, 16'h8001, 16'hFFF8, 16'h4000);
    // P = 2^24, Sp = 14 -> >>7 then >>6: 2048, scale 1
    step("two_stage",        1'b0, 16'h8007, 16'h8007, 16'h4001);
    step("zero_times",       1'b0, 16'h0000, 16'h0039, 16'h0001);
    // Reset mid-stream with live operands, then first edge after release
    step("reset_mid",        1'b1, 16'h0039, 16'h02A4, 16'h0000);
    step("after_reset",      1'b0, 16'hFF99, 16'h0020, 16'hFE61);
    step("back_to_back",     1'b0, 16'h00DA, 16'hFFE0, 16'hFCA2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multiplier.md
MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 Parameter DATA_W, default 16: total operand and result width; only the default must be supported.
REQ-002 Parameter SCALE_W, default 3: width of the scale field in the low bits; only the default must be supported.
REQ-003 The block SHALL use one clock with a synchronous, active-high reset.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port first_operand, input, 16 bits: packed fixed-point operand A.
REQ-007 Port second_operand, input, 16 bits: packed fixed-point operand B.
REQ-008 Port out, output, 16 bits: packed fixed-point product, registered.

Function
REQ-009 Packed format SHALL be [15:3] = signed two's-complement mantissa M (-4096..4095) and [2:0] = unsigned scale S (0..7); value = M * 2^-S.
REQ-010 The full product SHALL be P = MA * MB, computed as a 26-bit signed value with no loss, and Sp = SA + SB (0..14).
REQ-011 Normalisation, stage 1: if Sp > 7, arithmetic-shift P right by (Sp - 7) and set Sp = 7.
REQ-012 Normalisation, stage 2: while P lies outside -4096..4095 and Sp > 0, arithmetic-shift P right by 1 and decrement Sp; use the minimal number of shifts.
REQ-013 All right shifts SHALL truncate toward negative infinity (arithmetic shift); no rounding.
REQ-014 If P still lies outside -4096..4095 at Sp = 0, the mantissa SHALL saturate to 4095 (P > 0) or -4096 (P < 0) with scale 0.
REQ-015 If no shift is needed, the result SHALL be exact: out = {P[12:0], Sp[2:0]}.
REQ-016 A zero product SHALL give mantissa 0 with scale = min(Sp, 7).
REQ-017 Latency SHALL be exactly 1 cycle: out at edge n+1 reflects the operands sampled at edge n.
REQ-018 There SHALL be no handshake; the block accepts new operands every cycle (throughput 1/cycle).
REQ-019 The datapath before the output register SHALL be purely combinational, with no internal state beyond the out register.

Reset
REQ-020 While rst = 1 at a rising edge, out SHALL become 16'h0000.
REQ-021 Reset SHALL take priority over operand capture.
REQ-022 On the first edge after rst deasserts, out SHALL reflect the operands present at that edge.

Verification
REQ-023 Exact positive case: A = 0x0039 (3.5, S=1), B = 0x02A4 (5.25, S=4) -> out = 0x1265 (M=588, S=5, value 18.375) one cycle later.
REQ-024 Negative-by-positive case: A = 0xFF99 (-6.5), B = 0x0020 (4, S=0) -> out = 0xFE61 (M=-52, S=1, value -26).
REQ-025 Positive-by-negative case: A = 0x00DA (6.75, S=2), B = 0xFFE0 (-4, S=0) -> out = 0xFCA2 (M=-108, S=2, value -27).
REQ-026 Scale-overflow normalisation: A = 0x051D (5.09375, S=5), B = 0x058D (5.53125, S=5) -> P = 28851, Sp = 10 -> out = 0x70B7 (M=3606, S=7, value 28.171875, truncated).
REQ-027 Range normalisation: A = 0x7FFA (4095, S=2), B = 0x0010 (2, S=0) -> out = 0x7FF9 (M=4095, S=1).
REQ-028 Saturation: A = B = 0x7FF8 -> out = 0x7FF8.
REQ-029 Saturation, negative: A = 0x8000 (-4096, S=0), B = 0x0010 (2, S=0) -> out = 0x8000 (M=-4096, S=0).
REQ-030 Reset check: assert rst mid-stream with non-zero operands applied -> out = 0x0000 at the next edge.
